// File: rtl/control_barrido_pkg.sv
// control_barrido_pkg
// Shared definitions for the digit-3 pattern selector: FSM state encoding and
// the three segment patterns, so the display decoder can compare against the
// same named values.
package control_barrido_pkg;

   typedef enum logic [1:0] {
      S_CERO = 2'd0,
      S_UNO  = 2'd1,
      S_OTRO = 2'd2
   } estado_fsm_t;

   localparam logic [7:0] PAT_CERO = 8'b10000001;
   localparam logic [7:0] PAT_UNO  = 8'b11001111;
   localparam logic [7:0] PAT_OTRO = 8'b10010010;

   function automatic logic [7:0] patron(input estado_fsm_t s);
      case (s)
         S_CERO:  patron = PAT_CERO;
         S_UNO:   patron = PAT_UNO;
         S_OTRO:  patron = PAT_OTRO;
         default: patron = PAT_CERO;
      endcase
   endfunction

endpackage

// File: rtl/antirrebote.sv
// antirrebote
// Push-button conditioner: 2-FF synchroniser, debounce counter and a
// single-cycle pulse on each accepted press (0->1 of the accepted level).
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   boton  in  raw asynchronous button, active-high
//   pulso  out one-cycle pulse per debounced press
module antirrebote #(
   parameter int DEB_CICLOS = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic boton,
   output logic pulso
);

   localparam int CW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
   localparam logic [CW-1:0] CNT_FIN = CW'(DEB_CICLOS - 1);

   logic          sinc_p0;
   logic          sinc_p1;
   logic          nivel;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sinc_p0 <= 1'b0;
         sinc_p1 <= 1'b0;
         nivel   <= 1'b0;
         cnt     <= '0;
         pulso   <= 1'b0;
      end else begin
         // synchroniser stages
         sinc_p0 <= boton;
         sinc_p1 <= sinc_p0;
         pulso   <= 1'b0;
         // count only while the synchronised level disagrees with the
         // accepted one; any agreement restarts the stable window
         if (sinc_p1 == nivel) begin
            cnt <= '0;
         end else if (cnt == CNT_FIN) begin
            nivel <= sinc_p1;
            cnt   <= '0;
            pulso <= sinc_p1;    // releases produce no pulse
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/control_barrido.sv
// control_barrido
// Drives the seven-segment stage: a refresh prescaler steps the digit-scan
// index, and a debounced button advances a three-state FSM whose state selects
// the pattern for digit 3. Scan and FSM are fully independent.
// Ports:
//   clk            in  system clock
//   reset          in  synchronous, active-high
//   boton          in  raw push-button, active-high
//   conteo         out 2-bit digit-scan index
//   estado         out 8-bit segment pattern for digit 3
//   tick_refresco  out one-cycle pulse in the cycle conteo advances
module control_barrido
   import control_barrido_pkg::*;
#(
   parameter int DIV_REFRESCO = 50_000,
   parameter int DEB_CICLOS   = 500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       boton,
   output logic [1:0] conteo,
   output logic [7:0] estado,
   output logic       tick_refresco
);

   localparam int RW = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
   localparam logic [RW-1:0] REF_FIN = RW'(DIV_REFRESCO - 1);

   logic [RW-1:0] cnt_ref;
   logic          pulso;
   estado_fsm_t   state_q;
   estado_fsm_t   state_d;

   antirrebote #(
      .DEB_CICLOS(DEB_CICLOS)
   ) u_antirrebote (
      .clk   (clk),
      .reset (reset),
      .boton (boton),
      .pulso (pulso)
   );

   // the wrap cycle of the prescaler is the cycle conteo advances
   assign tick_refresco = (cnt_ref == REF_FIN);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_ref <= '0;
         conteo  <= 2'b00;
      end else if (tick_refresco) begin
         cnt_ref <= '0;
         conteo  <= conteo + 2'b01;
      end else begin
         cnt_ref <= cnt_ref + 1'b1;
      end
   end

   // estado is registered from the next state so it follows pulso by one edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_CERO;
         estado  <= PAT_CERO;
      end else begin
         state_q <= state_d;
         estado  <= patron(state_d);
      end
   end

   always_comb begin
      state_d = state_q;
      if (pulso) begin
         case (state_q)
            S_CERO:  state_d = S_UNO;
            S_UNO:   state_d = S_OTRO;
            S_OTRO:  state_d = S_CERO;
            default: state_d = S_CERO;
         endcase
      end
   end

endmodule

// File: tb/tb_control_barrido.sv
// tb_control_barrido
// Self-checking bench for control_barrido with DIV_REFRESCO=4, DEB_CICLOS=8.
// A reset/scan vector table, hand-written multi-cycle sequences and a random
// button phase, all compared every cycle against a behavioural model.
module tb_control_barrido;

   localparam int DIV = 4;
   localparam int DEB = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       boton = 1'b0;
   logic [1:0] conteo;
   logic [7:0] estado;
   logic       tick_refresco;

   control_barrido #(
      .DIV_REFRESCO(DIV),
      .DEB_CICLOS  (DEB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .boton         (boton),
      .conteo        (conteo),
      .estado        (estado),
      .tick_refresco (tick_refresco)
   );

   always #5 clk = ~clk;

   int chk_total = 0;
   int chk_ok    = 0;

   // behavioural model state
   int   m_n;          // cycles since reset released
   int   m_presses;    // debounced presses taking effect so far
   bit   m_pend;       // press accepted, pattern changes on next edge
   bit   m_acc;        // accepted button level
   bit   bq[$];        // raw button level of every cycle since release
   bit   win[$];       // consecutive disagreeing synchronised samples
   logic [7:0] pats [3] = '{8'b10000001, 8'b11001111, 8'b10010010};

   typedef struct {
      bit         rst;
      bit         bot;
      logic [1:0] conteo;
      logic [7:0] estado;
      bit         tick;
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_total++;
      if (act === exp) chk_ok++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model of one clock edge with inputs (r, b) held during the cycle.
   // The synchronised level seen in cycle n is the raw level from cycle n-2.
   task automatic model_edge(input bit r, input bit b);
      bit s;
      if (r) begin
         m_n = 0; m_presses = 0; m_pend = 0; m_acc = 0;
         bq.delete(); win.delete();
      end else begin
         if (m_pend) m_presses++;
         m_pend = 0;
         s = (m_n >= 2) ? bq[m_n-2] : 1'b0;
         if (s == m_acc) win.delete();
         else begin
            win.push_back(s);
            if (win.size() == DEB) begin
               m_acc = s;
               win.delete();
               m_pend = s;
            end
         end
         bq.push_back(b);
         m_n++;
      end
   endtask

   task automatic step(input bit r, input bit b);
      reset = r;
      boton = b;
      @(posedge clk);
      model_edge(r, b);
      #1;
      check("m_conteo", conteo, (m_n / DIV) % 4);
      check("m_estado", estado, pats[m_presses % 3]);
      check("m_tick", tick_refresco, (m_n % DIV) == DIV - 1);
   endtask

   task automatic hold(input bit b, input int n);
      for (int i = 0; i < n; i++) step(1'b0, b);
   endtask

   initial begin
      bit lvl;
      int len;

      tbl[0]  = '{1, 0, 2'd0, 8'h81, 0};
      tbl[1]  = '{1, 0, 2'd0, 8'h81, 0};
      tbl[2]  = '{1, 0, 2'd0, 8'h81, 0};
      tbl[3]  = '{0, 0, 2'd0, 8'h81, 0};
      tbl[4]  = '{0, 0, 2'd0, 8'h81, 0};
      tbl[5]  = '{0, 0, 2'd0, 8'h81, 1};
      tbl[6]  = '{0, 0, 2'd1, 8'h81, 0};
      tbl[7]  = '{0, 0, 2'd1, 8'h81, 0};
      tbl[8]  = '{0, 0, 2'd1, 8'h81, 0};
      tbl[9]  = '{0, 0, 2'd1, 8'h81, 1};
      tbl[10] = '{0, 0, 2'd2, 8'h81, 0};
      tbl[11] = '{0, 0, 2'd2, 8'h81, 0};
      tbl[12] = '{0, 0, 2'd2, 8'h81, 0};
      tbl[13] = '{0, 0, 2'd2, 8'h81, 1};
      tbl[14] = '{0, 0, 2'd3, 8'h81, 0};
      tbl[15] = '{0, 0, 2'd3, 8'h81, 0};
      tbl[16] = '{0, 0, 2'd3, 8'h81, 0};
      tbl[17] = '{0, 0, 2'd3, 8'h81, 1};
      tbl[18] = '{0, 0, 2'd0, 8'h81, 0};

      // reset held 3 cycles then the scan sequence
      for (int i = 0; i < 19; i++) begin
         step(tbl[i].rst, tbl[i].bot);
         check("tbl_conteo", conteo, tbl[i].conteo);
         check("tbl_estado", estado, tbl[i].estado);
         check("tbl_tick", tick_refresco, tbl[i].tick);
      end

      // clean press held 20 cycles
      hold(1'b1, 10);
      check("press_before", estado, 8'b10000001);
      step(1'b0, 1'b1);
      check("press_at_11", estado, 8'b11001111);
      hold(1'b1, 9);
      check("press_held", estado, 8'b11001111);
      hold(1'b0, 12);
      check("press_release", estado, 8'b11001111);

      // three press/release pairs from reset
      step(1'b1, 1'b0);
      hold(1'b1, 12); hold(1'b0, 12);
      check("pair1", estado, 8'b11001111);
      hold(1'b1, 12); hold(1'b0, 12);
      check("pair2", estado, 8'b10010010);
      hold(1'b1, 12); hold(1'b0, 12);
      check("pair3_wrap", estado, 8'b10000001);

      // bounce: 5 high, 2 low, 5 high, low
      step(1'b1, 1'b0);
      hold(1'b1, 5); hold(1'b0, 2); hold(1'b1, 5); hold(1'b0, 15);
      check("bounce", estado, 8'b10000001);

      // reset in the middle of the stable window, button kept high
      step(1'b1, 1'b0);
      hold(1'b1, 6);
      step(1'b1, 1'b1);
      check("midrst_conteo", conteo, 2'b00);
      check("midrst_estado", estado, 8'b10000001);
      hold(1'b1, 10);
      check("midrst_before", estado, 8'b10000001);
      step(1'b0, 1'b1);
      check("midrst_after", estado, 8'b11001111);
      hold(1'b0, 12);

      // pulso aligned with tick_refresco (both in cycle 11)
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      hold(1'b1, 10);
      check("simul_tick", tick_refresco, 1'b1);
      check("simul_conteo_pre", conteo, 2'd2);
      check("simul_estado_pre", estado, 8'b10000001);
      step(1'b0, 1'b1);
      check("simul_conteo_post", conteo, 2'd3);
      check("simul_estado_post", estado, 8'b11001111);
      hold(1'b0, 12);

      // random button activity with occasional resets
      step(1'b1, 1'b0);
      for (int k = 0; k < 200; k++) begin
         lvl = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 14));
         for (int j = 0; j < len; j++)
            step($urandom_range(0, 199) == 0, lvl);
      end

      $display("%0d/%0d checks passed", chk_ok, chk_total);
      $finish;
   end

endmodule
